// File: rtl/cc1200_apb_master_if.sv
// Command/response handshake plus APB master bus for cc1200_apb_master.
// The master modport is the bridge's view; slave is the surrounding environment.
interface cc1200_apb_master_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;
  logic        busy;
  logic [31:0] APB_M_paddr;
  logic        APB_M_psel;
  logic        APB_M_penable;
  logic        APB_M_pwrite;
  logic [31:0] APB_M_pwdata;
  logic [31:0] APB_M_prdata;
  logic        APB_M_pready;
  logic        APB_M_pslverr;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
           APB_M_prdata, APB_M_pready, APB_M_pslverr,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, busy,
           APB_M_paddr, APB_M_psel, APB_M_penable, APB_M_pwrite, APB_M_pwdata
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
           APB_M_prdata, APB_M_pready, APB_M_pslverr,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, busy,
           APB_M_paddr, APB_M_psel, APB_M_penable, APB_M_pwrite, APB_M_pwdata
  );
endinterface

// File: rtl/cc1200_apb_master.sv
// Single-outstanding command-to-APB bridge with an ACCESS-phase watchdog.
// All outputs come from registers or from the FSM state, never from APB inputs.
module cc1200_apb_master #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                      clk,
  input  logic                      rstn,
  cc1200_apb_master_if.master       bus
);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_RESP} state_t;

  typedef struct packed {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
  } cmd_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic        timeout;
  } rsp_t;

  state_t      r_state, w_state_nxt;
  cmd_t        r_cmd;
  rsp_t        r_rsp;
  logic [15:0] r_cnt;
  logic [15:0] w_cnt_inc;
  logic        w_expire;

  assign w_cnt_inc = r_cnt + 16'd1;
  // Expiry is only acted on when pready is low, so a late pready still completes.
  assign w_expire  = (w_cnt_inc == 16'(TIMEOUT));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt       = r_state;
    bus.cmd_ready     = 1'b0;
    bus.APB_M_psel    = 1'b0;
    bus.APB_M_penable = 1'b0;
    bus.rsp_valid     = 1'b0;
    bus.busy          = 1'b1;
    case (r_state)
      S_IDLE: begin
        bus.cmd_ready = 1'b1;
        bus.busy      = 1'b0;
        if (bus.cmd_valid) w_state_nxt = S_SETUP;
      end
      S_SETUP: begin
        bus.APB_M_psel = 1'b1;
        w_state_nxt    = S_ACCESS;
      end
      S_ACCESS: begin
        bus.APB_M_psel    = 1'b1;
        bus.APB_M_penable = 1'b1;
        if (bus.APB_M_pready || w_expire) w_state_nxt = S_RESP;
      end
      S_RESP: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cmd <= '0;
      r_rsp <= '0;
      r_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.cmd_valid) begin
            r_cmd.write <= bus.cmd_write;
            r_cmd.addr  <= bus.cmd_addr;
            r_cmd.wdata <= bus.cmd_wdata;
            r_cnt       <= '0;
          end
        end
        S_ACCESS: begin
          if (bus.APB_M_pready) begin
            r_rsp.rdata   <= r_cmd.write ? 32'h0 : bus.APB_M_prdata;
            r_rsp.err     <= bus.APB_M_pslverr;
            r_rsp.timeout <= 1'b0;
          end else begin
            r_cnt <= w_cnt_inc;
            if (w_expire) begin
              r_rsp.rdata   <= 32'h0;
              r_rsp.err     <= 1'b1;
              r_rsp.timeout <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.APB_M_paddr  = r_cmd.addr;
  assign bus.APB_M_pwrite = r_cmd.write;
  assign bus.APB_M_pwdata = r_cmd.wdata;
  assign bus.rsp_rdata    = r_rsp.rdata;
  assign bus.rsp_err      = r_rsp.err;
  assign bus.rsp_timeout  = r_rsp.timeout;

  a_setup_one_cycle: assert property (@(posedge clk) disable iff (!rstn)
    (r_state == S_SETUP) |=> (r_state == S_ACCESS));
  a_no_overlap: assert property (@(posedge clk) disable iff (!rstn)
    !(bus.cmd_ready && bus.rsp_valid));

endmodule

// File: tb/tb_cc1200_apb_master.sv
// Random + directed bench: a stimulus process plans each transfer, a slave model
// plays it back on APB, and a monitor scores responses against the planned outcome.
module tb_cc1200_apb_master;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  cc1200_apb_master_if bus();
  cc1200_apb_master #(.TIMEOUT(TO)) dut (.clk(clk), .rstn(rstn), .bus(bus));

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          w;
    bit          err;
  } plan_t;

  typedef struct {
    logic [31:0] rdata;
    bit          err;
    bit          to;
    int          lat;
    int          acc;
  } exp_t;

  plan_t plan_q[$];
  exp_t  exp_q[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  int    n_acc = 0;
  int    n_hs = 0;
  int    last_hs = -1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Slave model: replays the planned wait count / error / read data
  initial begin
    plan_t cur;
    bit    have = 0;
    int    acnt = 0;
    bus.APB_M_pready  = 1'b0;
    bus.APB_M_pslverr = 1'b0;
    bus.APB_M_prdata  = '0;
    forever begin
      @(posedge clk); #1;
      if (bus.APB_M_psel && !bus.APB_M_penable) begin
        if (plan_q.size() == 0) begin
          fail("setup_without_command");
          have = 0;
        end else begin
          cur  = plan_q.pop_front();
          have = 1;
          chk("setup_paddr", bus.APB_M_paddr, cur.addr);
          chk("setup_pwrite", 32'(bus.APB_M_pwrite), 32'(cur.wr));
          if (cur.wr) chk("setup_pwdata", bus.APB_M_pwdata, cur.wdata);
        end
        acnt = 0;
        // junk on pready/pslverr outside ACCESS must be ignored
        bus.APB_M_pready  = 1'($urandom);
        bus.APB_M_pslverr = 1'($urandom);
        bus.APB_M_prdata  = $urandom;
      end else if (bus.APB_M_psel && bus.APB_M_penable && have) begin
        chk("access_paddr", bus.APB_M_paddr, cur.addr);
        chk("access_pwrite", 32'(bus.APB_M_pwrite), 32'(cur.wr));
        if (cur.wr) chk("access_pwdata", bus.APB_M_pwdata, cur.wdata);
        if (acnt == cur.w) begin
          bus.APB_M_pready  = 1'b1;
          bus.APB_M_pslverr = cur.err;
          bus.APB_M_prdata  = cur.rdata;
        end else begin
          bus.APB_M_pready  = 1'b0;
          bus.APB_M_pslverr = 1'($urandom);
          bus.APB_M_prdata  = $urandom;
        end
        acnt++;
      end else begin
        bus.APB_M_pready  = 1'($urandom);
        bus.APB_M_pslverr = 1'($urandom);
        bus.APB_M_prdata  = $urandom;
      end
    end
  end

  // Response monitor: scores new responses, checks stability while backpressured
  initial begin
    exp_t        e;
    bit          in_rsp = 0;
    int          bp_left = 0;
    logic [31:0] h_rdata;
    logic        h_err, h_to;
    bus.rsp_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        bus.rsp_ready = 1'b0;
        in_rsp = 0;
        bp_left = 0;
      end else if (bus.rsp_valid) begin
        if (!in_rsp) begin
          if (exp_q.size() == 0) fail("unexpected_response");
          else begin
            e = exp_q.pop_front();
            chk("rsp_rdata", bus.rsp_rdata, e.rdata);
            chk("rsp_err", 32'(bus.rsp_err), 32'(e.err));
            chk("rsp_timeout", 32'(bus.rsp_timeout), 32'(e.to));
            chk("rsp_latency", 32'(cyc - e.acc), 32'(e.lat));
          end
          h_rdata = bus.rsp_rdata;
          h_err   = bus.rsp_err;
          h_to    = bus.rsp_timeout;
          if ($urandom_range(0, 3) == 0) bp_left = 5;
        end else begin
          chk("hold_rdata", bus.rsp_rdata, h_rdata);
          chk("hold_err", 32'(bus.rsp_err), 32'(h_err));
          chk("hold_timeout", 32'(bus.rsp_timeout), 32'(h_to));
        end
        chk("cmd_ready_in_resp", 32'(bus.cmd_ready), 32'd0);
        chk("psel_in_resp", 32'(bus.APB_M_psel), 32'd0);
        if (bp_left > 0) begin
          bus.rsp_ready = 1'b0;
          bp_left--;
        end else begin
          bus.rsp_ready = ($urandom_range(0, 2) != 0);
        end
        in_rsp = !bus.rsp_ready;
        if (bus.rsp_ready) begin
          n_hs++;
          last_hs = cyc + 1;
        end
      end else begin
        bus.rsp_ready = 1'($urandom);
        in_rsp = 0;
      end
    end
  end

  task automatic wait_accept(output bit ok, output int acc);
    int n = 0;
    do begin
      @(negedge clk);
      ok = bus.cmd_ready;
      @(posedge clk); #1;
      n++;
    end while (!ok && n < 3000);
    acc = cyc;
    if (!ok) fail("accept_wait_expired");
  endtask

  // Outcome from the protocol rules: wait W cycles, pready wins until TIMEOUT passes
  task automatic txn(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [31:0] rdata, input int w, input bit err, input bit keep);
    plan_t p;
    exp_t  e;
    bit    ok;
    int    acc;
    p.wr = wr; p.addr = addr; p.wdata = wdata; p.rdata = rdata; p.w = w; p.err = err;
    plan_q.push_back(p);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr  = addr;
    bus.cmd_wdata = wdata;
    wait_accept(ok, acc);
    if (!ok) return;
    chk("accept_after_handshake", 32'((n_acc == n_hs) && (acc > last_hs)), 32'd1);
    n_acc++;
    e.to    = (w >= TO);
    e.err   = e.to ? 1'b1 : err;
    e.rdata = (e.to || wr) ? 32'h0 : rdata;
    e.lat   = 2 + (e.to ? TO - 1 : w);
    e.acc   = acc;
    exp_q.push_back(e);
    if (!keep) begin
      bus.cmd_valid = 1'b0;
      bus.cmd_addr  = $urandom;
      bus.cmd_wdata = $urandom;
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || bus.busy) && n < 5000) begin @(posedge clk); #1; n++; end
    if (n >= 5000) fail("drain_expired");
  endtask

  initial begin
    int w, sel;
    bit ok;
    int acc;
    rstn = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_psel", 32'(bus.APB_M_psel), 32'd0);
    chk("rst_penable", 32'(bus.APB_M_penable), 32'd0);
    chk("rst_pwrite", 32'(bus.APB_M_pwrite), 32'd0);
    chk("rst_paddr", bus.APB_M_paddr, 32'h0);
    chk("rst_pwdata", bus.APB_M_pwdata, 32'h0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
    chk("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
    chk("rst_rsp_timeout", 32'(bus.rsp_timeout), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    rstn = 1'b1;
    @(negedge clk);
    chk("post_rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    @(posedge clk); #1;

    txn(1'b1, 32'h14, 32'h10, 32'h0, 1, 1'b0, 1'b0);
    txn(1'b0, 32'h0C, 32'h0, 32'hDEADBEEF, 0, 1'b0, 1'b0);
    txn(1'b0, 32'h40, 32'h0, 32'h12345678, 0, 1'b1, 1'b0);
    txn(1'b0, 32'h80, 32'h0, 32'hCAFEF00D, TO, 1'b0, 1'b0);
    txn(1'b0, 32'h84, 32'h0, 32'hA5A5A5A5, TO - 1, 1'b0, 1'b1);
    txn(1'b1, 32'h88, 32'h55, 32'h0, 1000, 1'b0, 1'b1);
    txn(1'b1, 32'h8C, 32'h66, 32'h0, TO - 2, 1'b1, 1'b0);

    for (int i = 0; i < 150; i++) begin
      sel = $urandom_range(0, 9);
      if (sel < 6)      w = $urandom_range(0, 3);
      else if (sel < 8) w = $urandom_range(TO - 2, TO);
      else              w = TO + $urandom_range(1, 8);
      txn(1'($urandom), $urandom, $urandom, $urandom, w, 1'($urandom), ($urandom_range(0, 2) == 0));
    end
    bus.cmd_valid = 1'b0;
    drain();

    // Abort mid-ACCESS: no response may follow for this command
    plan_q.push_back('{wr: 1'b0, addr: 32'hF0, wdata: 32'h0, rdata: 32'h1, w: 1000, err: 1'b0});
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 32'hF0;
    wait_accept(ok, acc);
    bus.cmd_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    chk("pre_abort_penable", 32'(bus.APB_M_penable), 32'd1);
    #2 rstn = 1'b0;
    #1;
    chk("abort_psel", 32'(bus.APB_M_psel), 32'd0);
    chk("abort_penable", 32'(bus.APB_M_penable), 32'd0);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    if (ok) begin n_acc++; n_hs++; end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("post_abort_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("post_abort_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    end
    @(posedge clk); #1;
    txn(1'b0, 32'h0C, 32'h0, 32'h0BADF00D, 2, 1'b0, 1'b0);
    drain();
    chk("plans_consumed", 32'(plan_q.size()), 32'd0);
    chk("responses_consumed", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_watchdog (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end
endmodule
